// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: peripheral window base, timer register map and
// CTRL/STAT bit positions used by bus_timer and its core.
package cpu_bus_pkg;

    localparam logic [15:0] TIMER_BASE_DEFAULT = 16'hFE00;

    typedef enum logic [2:0] {
        REG_CNT_LO = 3'd0,
        REG_CNT_HI = 3'd1,
        REG_RLD_LO = 3'd2,
        REG_RLD_HI = 3'd3,
        REG_CTRL   = 3'd4,
        REG_STAT   = 3'd5,
        REG_PRESC  = 3'd6,
        REG_RSVD   = 3'd7
    } timer_reg_e;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int STAT_UF      = 0;
    localparam int STAT_RUN     = 7;

endpackage

// File: rtl/bus_timer_core.sv
// Down-counter with reload, underflow flag and optional tick prescaler.
// The prescaler exists only when BUS_TIMER_PRESCALE_EN is defined.
module bus_timer_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
`ifdef BUS_TIMER_PRESCALE_EN
    input  logic [7:0]  presc,
`endif
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic [15:0] reload,
    input  logic        uf_clr,
    output logic [15:0] count,
    output logic        uf,
    output logic        uf_event
);

    logic [15:0] count_reg;
    logic        uf_reg;
    logic        tick;

`ifdef BUS_TIMER_PRESCALE_EN
    logic [7:0] presc_cnt_reg;

    // Prescaler is held at zero while stopped so every start begins a full period.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            presc_cnt_reg <= 8'h00;
        end else if (presc_cnt_reg == presc) begin
            presc_cnt_reg <= 8'h00;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + 8'h01;
        end
    end

    assign tick = run && (presc_cnt_reg == presc);
`else
    assign tick = run;
`endif

    // A software load of the counter overrides the whole tick, underflow included.
    assign uf_event = tick && !load && (count_reg == 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 16'h0000;
            uf_reg    <= 1'b0;
        end else begin
            if (load) begin
                count_reg <= load_value;
            end else if (tick) begin
                count_reg <= (count_reg == 16'h0000) ? reload : count_reg - 16'h0001;
            end

            if (uf_event) begin
                uf_reg <= 1'b1;
            end else if (uf_clr) begin
                uf_reg <= 1'b0;
            end
        end
    end

    assign count = count_reg;
    assign uf    = uf_reg;

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit timer: address decode, register file and registered
// read mux. PRESC is functional only with BUS_TIMER_PRESCALE_EN defined.
module bus_timer
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] BASE = TIMER_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        hit,
    output logic        irq
);

    logic       sel;
    timer_reg_e offset;
    logic       wr_en;
    logic       rd_en;

    logic [7:0] rld_lo_reg;
    logic [7:0] rld_hi_reg;
    logic [2:0] ctrl_reg;
    logic [7:0] shadow_reg;
    logic [7:0] di_reg;
    logic       hit_reg;
    logic [7:0] rd_data;

    logic [15:0] count;
    logic        uf;
    logic        uf_event;
    logic        load;
    logic        uf_clr;

    assign sel    = (AB[15:3] == BASE[15:3]);
    assign offset = timer_reg_e'(AB[2:0]);
    assign wr_en  = sel && WE;
    assign rd_en  = sel && !WE;
    assign load   = wr_en && (offset == REG_RLD_HI);
    assign uf_clr = wr_en && (offset == REG_STAT) && DO[STAT_UF];

`ifdef BUS_TIMER_PRESCALE_EN
    logic [7:0] presc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= 8'h00;
        end else if (wr_en && (offset == REG_PRESC)) begin
            presc_reg <= DO;
        end
    end
`endif

    bus_timer_core u_core (
        .clk        (clk),
        .reset      (reset),
        .run        (ctrl_reg[CTRL_RUN]),
`ifdef BUS_TIMER_PRESCALE_EN
        .presc      (presc_reg),
`endif
        .load       (load),
        .load_value ({DO, rld_lo_reg}),
        .reload     ({rld_hi_reg, rld_lo_reg}),
        .uf_clr     (uf_clr),
        .count      (count),
        .uf         (uf),
        .uf_event   (uf_event)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rld_lo_reg <= 8'h00;
            rld_hi_reg <= 8'h00;
            ctrl_reg   <= 3'b000;
        end else begin
            if (wr_en && (offset == REG_RLD_LO)) rld_lo_reg <= DO;
            if (wr_en && (offset == REG_RLD_HI)) rld_hi_reg <= DO;
            if (wr_en && (offset == REG_CTRL))   ctrl_reg   <= DO[2:0];
            // One-shot stop is assigned last so it overrides a same-edge CTRL write.
            if (uf_event && ctrl_reg[CTRL_ONESHOT]) ctrl_reg[CTRL_RUN] <= 1'b0;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (offset)
            REG_CNT_LO: rd_data = count[7:0];
            REG_CNT_HI: rd_data = shadow_reg;
            REG_RLD_LO: rd_data = rld_lo_reg;
            REG_RLD_HI: rd_data = rld_hi_reg;
            REG_CTRL:   rd_data = {5'b00000, ctrl_reg};
            REG_STAT:   rd_data = {ctrl_reg[CTRL_RUN], 6'b000000, uf};
`ifdef BUS_TIMER_PRESCALE_EN
            REG_PRESC:  rd_data = presc_reg;
`endif
            default:    rd_data = 8'h00;
        endcase
    end

    // Non-selected cycles return zero so DI can be OR-merged onto the data bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            di_reg     <= 8'h00;
            hit_reg    <= 1'b0;
            shadow_reg <= 8'h00;
        end else begin
            hit_reg <= rd_en;
            di_reg  <= rd_en ? rd_data : 8'h00;
            if (rd_en && (offset == REG_CNT_LO)) shadow_reg <= count[15:8];
        end
    end

    assign DI  = di_reg;
    assign hit = hit_reg;
    assign irq = uf && ctrl_reg[CTRL_IRQ_EN];

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: read data/hit are scoreboarded one cycle
// after each bus cycle is driven; irq is checked at fixed cycle offsets.
module tb_bus_timer;

    localparam logic [15:0] TB_BASE = 16'hFE00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] AB = 16'h0000;
    logic [7:0]  DO = 8'h00;
    logic        WE = 1'b0;
    logic [7:0]  DI;
    logic        hit;
    logic        irq;

    logic rst_drv = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic [7:0] di;
        logic       hit;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    bus_timer #(.BASE(TB_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .AB    (AB),
        .DO    (DO),
        .WE    (WE),
        .DI    (DI),
        .hit   (hit),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: compare the output produced by the previous cycle, then
    // drive this cycle and queue what it must return one cycle later.
    task automatic step(input logic [15:0] ab, input logic we, input logic [7:0] d,
                        input logic [7:0] edi, input logic ehit, input string tag);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".di"}, {8'h00, DI}, {8'h00, e.di});
            check({e.tag, ".hit"}, {15'h0000, hit}, {15'h0000, e.hit});
            $display("cycle %s di=%h hit=%b irq=%b", e.tag, DI, hit, irq);
        end
        reset = rst_drv;
        AB    = ab;
        WE    = we;
        DO    = d;
        e.di  = edi;
        e.hit = ehit;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        step(16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, "idle");
    endtask

    task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string tag);
        step(TB_BASE + {13'd0, off}, 1'b0, 8'h00, exp, 1'b1, tag);
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        step(TB_BASE + {13'd0, off}, 1'b1, d, 8'h00, 1'b0, "wr");
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        check(tag, {15'h0000, irq}, {15'h0000, exp});
    endtask

    initial begin
        // Reset, including a read presented while reset is high.
        idle(); idle();
        chk_irq(1'b0, "irq_reset");
        step(TB_BASE, 1'b0, 8'h00, 8'h00, 1'b0, "rd_in_reset");
        rst_drv = 1'b0;
        idle();
        rd(3'd0, 8'h00, "rst_cnt_lo");
        rd(3'd2, 8'h00, "rst_rld_lo");
        rd(3'd4, 8'h00, "rst_ctrl");
        rd(3'd5, 8'h00, "rst_stat");

        // Periodic mode, reload 3, IRQ enabled: underflow every 4 ticks.
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h03);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk_irq(1'b0, "per_wait");
        end
        idle();          chk_irq(1'b1, "per_uf1");
        wr(3'd5, 8'h01); chk_irq(1'b1, "per_uf1_hold");
        idle();          chk_irq(1'b0, "per_clr");
        idle();          chk_irq(1'b0, "per_wait2");
        idle();          chk_irq(1'b1, "per_uf2");
        wr(3'd5, 8'h01); chk_irq(1'b1, "per_uf2_hold");
        idle();          chk_irq(1'b0, "per_clr2");
        // W1C lands on the same edge as the third underflow.
        wr(3'd5, 8'h01); chk_irq(1'b0, "w1c_pre");
        idle();          chk_irq(1'b1, "w1c_vs_uf");
        idle();          chk_irq(1'b1, "w1c_vs_uf_hold");
        wr(3'd4, 8'h00);

        // One-shot, reload 2, IRQ disabled.
        wr(3'd5, 8'h01);
        wr(3'd2, 8'h02);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h05);
        idle(); idle();
        rd(3'd5, 8'h80, "os_stat_run");
        rd(3'd5, 8'h01, "os_stat_uf");
        chk_irq(1'b0, "os_irq_masked");
        idle();
        rd(3'd0, 8'h02, "os_cnt_lo");
        rd(3'd1, 8'h00, "os_cnt_hi");
        rd(3'd4, 8'h04, "os_ctrl");

        // Coherent 16-bit read through the shadow.
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        rd(3'd0, 8'h00, "shadow_lo");
        wr(3'd3, 8'h00);
        rd(3'd1, 8'h01, "shadow_hi");
        rd(3'd1, 8'h01, "shadow_hi_again");

        // Window boundaries and the reserved register.
        step(TB_BASE + 16'd8, 1'b0, 8'h00, 8'h00, 1'b0, "rd_base8");
        step(TB_BASE - 16'd1, 1'b0, 8'h00, 8'h00, 1'b0, "rd_base_m1");
        rd(3'd7, 8'h00, "rd_rsvd");
        wr(3'd7, 8'hFF);
        rd(3'd7, 8'h00, "rd_rsvd_after_wr");
        step(TB_BASE + 16'd2, 1'b1, 8'h5A, 8'h00, 1'b0, "wr_no_hit");

        // Prescaler, reload 0.
        wr(3'd5, 8'h01);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h00);
`ifdef BUS_TIMER_PRESCALE_EN
        wr(3'd6, 8'h04);
        rd(3'd6, 8'h04, "presc_rb");
        wr(3'd4, 8'h01);
        idle(); idle(); idle(); idle();
        rd(3'd5, 8'h80, "psc_before");
        rd(3'd5, 8'h81, "psc_uf1");
        wr(3'd5, 8'h01);
        rd(3'd5, 8'h80, "psc_clr");
        rd(3'd5, 8'h80, "psc_wait_a");
        rd(3'd5, 8'h80, "psc_wait_b");
        rd(3'd5, 8'h81, "psc_uf2");
`else
        wr(3'd6, 8'h04);
        rd(3'd6, 8'h00, "presc_rb");
        wr(3'd4, 8'h01);
        rd(3'd5, 8'h80, "tick_before");
        rd(3'd5, 8'h81, "tick_uf1");
        wr(3'd5, 8'h01);
        rd(3'd5, 8'h81, "tick_every_cycle");
`endif

        // Reset while running with irq asserted and a read in flight.
        wr(3'd4, 8'h03);
        idle();
        chk_irq(1'b1, "pre_reset_irq");
        rst_drv = 1'b1;
        step(TB_BASE + 16'd4, 1'b0, 8'h00, 8'h00, 1'b0, "rd_at_reset");
        rst_drv = 1'b0;
        idle();
        chk_irq(1'b0, "post_reset_irq");
        rd(3'd4, 8'h00, "post_reset_ctrl");
        rd(3'd5, 8'h00, "post_reset_stat");
        rd(3'd6, 8'h00, "post_reset_presc");
        rd(3'd0, 8'h00, "post_reset_cnt");
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
